// File: rtl/occurrence_literal_fetcher.sv
// occurrence_literal_fetcher
// Feeds the temporal buffer wrapper of the WalkSAT flip pipeline. On start it
// latches the candidate literals of an unsatisfied clause and, for every
// candidate variable, reads that variable's clause-membership slots from the
// occurrence table. It strips the candidate's own literal from each returned
// clause and packs the NSAT-1 remaining literals per slot. One buffer write is
// emitted per candidate.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-low reset
//   start_i        begin a fetch (accepted only when idle)
//   cand_lits_i    NSAT candidate literals, candidate k at [k*LIT_W +: LIT_W]
//   mem_rd_en_o    occurrence table read strobe
//   mem_addr_o     read address {variable, slot}; 0 when not reading
//   mem_rd_data_i  clause literals, valid one cycle after the strobe
//   wr_en_o        temporal buffer write strobe
//   wr_index_o     candidate index of the write
//   wr_literals_o  packed clause remainders, slot s at [s*REM_W +: REM_W]
//   busy_o         fetch in progress
//   done_o         single-cycle completion pulse (with the last write)
//   err_o          sticky: a candidate was absent from a nonempty clause
module occurrence_literal_fetcher #(
  parameter int NSAT                  = 3,
  parameter int LITERAL_ADDRESS_WIDTH = 12,
  parameter int MAX_CLAUSE_MEMBERSHIP = 20
) (
  input  logic                                                             clk_i,
  input  logic                                                             rst_i,
  input  logic                                                             start_i,
  input  logic [NSAT*(LITERAL_ADDRESS_WIDTH+1)-1:0]                        cand_lits_i,
  output logic                                                             mem_rd_en_o,
  output logic [LITERAL_ADDRESS_WIDTH+$clog2(MAX_CLAUSE_MEMBERSHIP)-1:0]   mem_addr_o,
  input  logic [NSAT*(LITERAL_ADDRESS_WIDTH+1)-1:0]                        mem_rd_data_i,
  output logic                                                             wr_en_o,
  output logic [$clog2(NSAT)-1:0]                                          wr_index_o,
  output logic [(NSAT-1)*MAX_CLAUSE_MEMBERSHIP*(LITERAL_ADDRESS_WIDTH+1)-1:0] wr_literals_o,
  output logic                                                             busy_o,
  output logic                                                             done_o,
  output logic                                                             err_o
);

  localparam int LAW    = LITERAL_ADDRESS_WIDTH;
  localparam int MC     = MAX_CLAUSE_MEMBERSHIP;
  localparam int LIT_W  = LAW + 1;
  localparam int SLOT_W = $clog2(MC);
  localparam int IDX_W  = $clog2(NSAT);
  localparam int REM_W  = (NSAT - 1) * LIT_W;
  localparam int ASM_W  = REM_W * MC;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state;
  logic [NSAT*LAW-1:0] cand_var_q;   // candidate variables; polarity is irrelevant to lookup
  logic [NSAT-1:0]     cand_pol_unused;

  // Issue stage: the read currently presented on mem_addr_o.
  logic [IDX_W-1:0]    iss_cand;
  logic [SLOT_W-1:0]   iss_slot;
  // Process stage: the read whose data is on mem_rd_data_i this cycle.
  logic                p_act;
  logic                p_rd;
  logic [IDX_W-1:0]    p_cand;
  logic [SLOT_W-1:0]   p_slot;
  logic                drain_q;

  logic [ASM_W-1:0]    asm_q;
  logic [ASM_W-1:0]    asm_next;
  logic [LIT_W-1:0]    lit [NSAT];
  logic [REM_W-1:0]    rem;
  logic [LAW-1:0]      p_var;
  logic                hit;
  int unsigned         hit_pos;
  logic                clause_nz;

  logic                last_issue;
  logic [IDX_W-1:0]    nxt_cand;
  logic [SLOT_W-1:0]   nxt_slot;
  logic [LAW-1:0]      nxt_var;

  always_comb begin
    for (int unsigned k = 0; k < NSAT; k++) begin
      cand_pol_unused[k] = cand_lits_i[k*LIT_W + LAW];
    end
  end

  // Clause reduction. With no match the removal point defaults to the last
  // position, which keeps the first NSAT-1 literals unchanged.
  always_comb begin
    p_var   = cand_var_q[int'(p_cand)*LAW +: LAW];
    hit     = 1'b0;
    hit_pos = NSAT - 1;
    for (int unsigned i = 0; i < NSAT; i++) begin
      lit[i] = mem_rd_data_i[i*LIT_W +: LIT_W];
    end
    for (int unsigned i = 0; i < NSAT; i++) begin
      if (!hit && (lit[i][LAW-1:0] == p_var)) begin
        hit     = 1'b1;
        hit_pos = i;
      end
    end
    rem = '0;
    for (int unsigned i = 0; i < NSAT - 1; i++) begin
      rem[i*LIT_W +: LIT_W] = (i < hit_pos) ? lit[i] : lit[i+1];
    end
    clause_nz = |mem_rd_data_i;
    // Cycles without a read (zero candidate) contribute an empty slot.
    if (!p_rd) begin
      rem = '0;
    end
    asm_next = asm_q;
    asm_next[int'(p_slot)*REM_W +: REM_W] = rem;
  end

  always_comb begin
    last_issue = (iss_cand == IDX_W'(NSAT - 1)) && (iss_slot == SLOT_W'(MC - 1));
    if (iss_slot == SLOT_W'(MC - 1)) begin
      nxt_slot = '0;
      nxt_cand = iss_cand + 1'b1;
    end else begin
      nxt_slot = iss_slot + 1'b1;
      nxt_cand = iss_cand;
    end
    nxt_var = cand_var_q[int'(nxt_cand)*LAW +: LAW];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      cand_var_q    <= '0;
      iss_cand      <= '0;
      iss_slot      <= '0;
      p_act         <= 1'b0;
      p_rd          <= 1'b0;
      p_cand        <= '0;
      p_slot        <= '0;
      drain_q       <= 1'b0;
      asm_q         <= '0;
      mem_rd_en_o   <= 1'b0;
      mem_addr_o    <= '0;
      wr_en_o       <= 1'b0;
      wr_index_o    <= '0;
      wr_literals_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      wr_en_o     <= 1'b0;
      done_o      <= 1'b0;
      mem_rd_en_o <= 1'b0;
      mem_addr_o  <= '0;
      p_act       <= 1'b0;
      p_rd        <= 1'b0;

      if (p_act) begin
        asm_q <= asm_next;
        if (p_rd && !hit && clause_nz) begin
          err_o <= 1'b1;
        end
        // The last slot goes straight into the output register, so the write
        // does not wait for the assembly register, which the next candidate
        // starts overwriting in the following cycle.
        if (p_slot == SLOT_W'(MC - 1)) begin
          wr_en_o       <= 1'b1;
          wr_index_o    <= p_cand;
          wr_literals_o <= asm_next;
          done_o        <= (p_cand == IDX_W'(NSAT - 1));
        end
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= ISSUE;
            busy_o   <= 1'b1;
            err_o    <= 1'b0;
            iss_cand <= '0;
            iss_slot <= '0;
            for (int unsigned k = 0; k < NSAT; k++) begin
              cand_var_q[k*LAW +: LAW] <= cand_lits_i[k*LIT_W +: LAW];
            end
            if (cand_lits_i[LAW-1:0] != '0) begin
              mem_rd_en_o <= 1'b1;
              mem_addr_o  <= {cand_lits_i[LAW-1:0], SLOT_W'(0)};
            end
          end
        end
        ISSUE: begin
          p_act  <= 1'b1;
          p_rd   <= mem_rd_en_o;
          p_cand <= iss_cand;
          p_slot <= iss_slot;
          if (last_issue) begin
            state   <= DRAIN;
            drain_q <= 1'b0;
          end else begin
            iss_cand <= nxt_cand;
            iss_slot <= nxt_slot;
            if (nxt_var != '0) begin
              mem_rd_en_o <= 1'b1;
              mem_addr_o  <= {nxt_var, nxt_slot};
            end
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            drain_q <= 1'b0;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_occurrence_literal_fetcher.sv
// Bench for occurrence_literal_fetcher (NSAT=3, LAW=12, MC=4). A behavioural
// model derives the expected cycle schedule and packed remainders from the
// candidate list and a table-driven occurrence memory; a compare process checks
// every output each cycle, and directed hand-computed checks pin the model.
module tb_occurrence_literal_fetcher;
  localparam int NSAT   = 3;
  localparam int LAW    = 12;
  localparam int MC     = 4;
  localparam int LIT_W  = LAW + 1;
  localparam int SLOT_W = 2;
  localparam int IDX_W  = 2;
  localparam int REM_W  = (NSAT - 1) * LIT_W;
  localparam int OUT_W  = REM_W * MC;
  localparam int CL_W   = NSAT * LIT_W;

  logic              clk;
  logic              rst_i;
  logic              start_i;
  logic [CL_W-1:0]   cand_lits_i;
  logic              mem_rd_en_o;
  logic [LAW+SLOT_W-1:0] mem_addr_o;
  logic [CL_W-1:0]   mem_rd_data_i;
  logic              wr_en_o;
  logic [IDX_W-1:0]  wr_index_o;
  logic [OUT_W-1:0]  wr_literals_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  occurrence_literal_fetcher #(
    .NSAT(NSAT),
    .LITERAL_ADDRESS_WIDTH(LAW),
    .MAX_CLAUSE_MEMBERSHIP(MC)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .cand_lits_i(cand_lits_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_rd_data_i(mem_rd_data_i),
    .wr_en_o(wr_en_o), .wr_index_o(wr_index_o), .wr_literals_o(wr_literals_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CL_W-1:0] mk(input int a, input int b, input int c);
    return {LIT_W'(c), LIT_W'(b), LIT_W'(a)};
  endfunction

  // Occurrence memory: explicit overrides, otherwise a default clause with the
  // variable at position s%NSAT (negated on odd slots) and filler literals.
  logic [CL_W-1:0] ovr [int unsigned];

  function automatic logic [CL_W-1:0] clause(input int unsigned v, input int unsigned s);
    logic [CL_W-1:0] c;
    int unsigned key;
    key = v * MC + s;
    if (ovr.exists(key)) return ovr[key];
    c = '0;
    for (int unsigned i = 0; i < NSAT; i++) begin
      if (i == s % NSAT) c[i*LIT_W +: LIT_W] = LIT_W'(((s % 2) << LAW) | v);
      else               c[i*LIT_W +: LIT_W] = LIT_W'(100 + s * 3 + i);
    end
    return c;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rd_data_i <= clause(int'(mem_addr_o >> SLOT_W), int'(mem_addr_o) % MC);
    else             mem_rd_data_i <= CL_W'({$urandom(), $urandom()});
  end

  // Remove the first literal on variable v, keep the rest in order.
  function automatic logic [REM_W-1:0] reduce(input logic [CL_W-1:0] c, input int unsigned v,
                                              output bit e);
    logic [LIT_W-1:0] q[$];
    logic [LIT_W-1:0] l;
    logic [REM_W-1:0] r;
    bit removed, any;
    removed = 0; any = 0;
    for (int i = 0; i < NSAT; i++) begin
      l = c[i*LIT_W +: LIT_W];
      if (l != 0) any = 1;
      if (!removed && l[LAW-1:0] == LAW'(v)) removed = 1;
      else q.push_back(l);
    end
    r = '0;
    for (int i = 0; i < NSAT - 1; i++) r[i*LIT_W +: LIT_W] = q[i];
    e = any && !removed;
    return r;
  endfunction

  // Model: m_c is the cycle number relative to the accept edge.
  bit               m_active = 0;
  int               m_c = 0;
  logic [CL_W-1:0]  m_cands = '0;
  logic [OUT_W-1:0] m_wr [NSAT];
  logic [OUT_W-1:0] m_held = '0;
  int               m_err_cyc = -1;
  bit               m_err = 0;

  function automatic int unsigned m_var(input int k);
    logic [LIT_W-1:0] l;
    l = m_cands[k*LIT_W +: LIT_W];
    return int'(l[LAW-1:0]);
  endfunction

  always @(posedge clk) begin
    bit e;
    if (!rst_i) begin
      m_active = 0; m_c = 0; m_err = 0; m_held = '0;
    end else begin
      if (m_active) begin
        m_c++;
        if (m_c > NSAT * MC + 2) m_active = 0;
      end else if (start_i) begin
        m_active = 1; m_c = 1; m_err = 0; m_err_cyc = -1;
        m_cands = cand_lits_i;
        for (int k = 0; k < NSAT; k++) begin
          m_wr[k] = '0;
          for (int s = 0; s < MC; s++) begin
            if (m_var(k) != 0) begin
              m_wr[k][s*REM_W +: REM_W] = reduce(clause(m_var(k), s), m_var(k), e);
              if (e && m_err_cyc < 0) m_err_cyc = k * MC + s + 3;
            end
          end
        end
      end
      if (m_active) begin
        if (m_c >= MC + 2 && (m_c - 2) % MC == 0) m_held = m_wr[(m_c - 2) / MC - 1];
        if (m_err_cyc >= 0 && m_c == m_err_cyc) m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit erd, ewr;
    int eaddr, v;
    if (cmp_en) begin
      erd = 0; eaddr = 0;
      if (m_active && m_c <= NSAT * MC) begin
        v = int'(m_var((m_c - 1) / MC));
        if (v != 0) begin
          erd = 1;
          eaddr = v * (1 << SLOT_W) + (m_c - 1) % MC;
        end
      end
      ewr = m_active && m_c >= MC + 2 && (m_c - 2) % MC == 0;
      chk("busy", 128'(busy_o), 128'(m_active));
      chk("rd_en", 128'(mem_rd_en_o), 128'(erd));
      chk("addr", 128'(mem_addr_o), 128'(eaddr));
      chk("wr_en", 128'(wr_en_o), 128'(ewr));
      chk("done", 128'(done_o), 128'(m_active && m_c == NSAT * MC + 2));
      chk("err", 128'(err_o), 128'(m_err));
      chk("wr_literals", 128'(wr_literals_o), 128'(m_held));
      if (ewr) chk("wr_index", 128'(wr_index_o), 128'((m_c - 2) / MC - 1));
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] wl;
    rst_i = 0; start_i = 0; cand_lits_i = '0;
    @(negedge clk); cmp_en = 1;
    @(negedge clk);
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_wr_en", 128'(wr_en_o), 128'(0));
    chk("rst_lits", 128'(wr_literals_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    rst_i = 1;
    @(negedge clk);

    // Run 1: basic fetch {+5,-7,+9}
    ovr[5*MC+0] = mk(5, 'h1002, 3);
    ovr[5*MC+1] = mk(4, 'h1005, 'h1005);
    ovr[7*MC+3] = '0;
    cand_lits_i = mk(5, 'h1007, 9); start_i = 1; cyc = 0;
    step(); start_i = 0;
    chk("h_addr_c1", 128'(mem_addr_o), 128'(20));
    chk("h_rd_c1", 128'(mem_rd_en_o), 128'(1));
    step(); step(); start_i = 1;               // ignored while busy
    step(); start_i = 0;
    step(); chk("h_addr_c5", 128'(mem_addr_o), 128'(28));
    step();
    wl = wr_literals_o;
    chk("h_wr_c6", 128'(wr_en_o), 128'(1));
    chk("h_idx_c6", 128'(wr_index_o), 128'(0));
    chk("h_slot0", 128'(wl[0 +: REM_W]), 128'({13'd3, 13'h1002}));
    chk("h_slot1", 128'(wl[REM_W +: REM_W]), 128'({13'h1005, 13'd4}));
    chk("h_write0", 128'(wl), 128'({13'd111, 13'd110, 13'd107, 13'd106, 13'h1005, 13'd4, 13'd3, 13'h1002}));
    repeat (4) step();
    wl = wr_literals_o;
    chk("h_wr_c10", 128'(wr_en_o), 128'(1));
    chk("h_idx_c10", 128'(wr_index_o), 128'(1));
    chk("h_zero_clause", 128'(wl[3*REM_W +: REM_W]), 128'(0));
    repeat (2) step(); chk("h_addr_c12", 128'(mem_addr_o), 128'(39));
    repeat (2) step();
    chk("h_done_c14", 128'(done_o), 128'(1));
    chk("h_idx_c14", 128'(wr_index_o), 128'(2));
    chk("h_err_run1", 128'(err_o), 128'(0));
    step(); chk("h_busy_c15", 128'(busy_o), 128'(0));

    // Run 2: back-to-back, zero candidate, error path
    ovr[5*MC+2] = mk(1, 2, 3);
    cand_lits_i = mk(5, 0, 9); start_i = 1; cyc = 0;
    step(); start_i = 0;
    repeat (3) step(); chk("h_err_c4", 128'(err_o), 128'(0));
    step(); chk("h_err_c5", 128'(err_o), 128'(1));
    for (int c = 5; c <= 8; c++) begin
      chk("h_no_rd", 128'(mem_rd_en_o), 128'(0));
      if (cyc == 6) begin
        wl = wr_literals_o;
        chk("h_err_slot", 128'(wl[2*REM_W +: REM_W]), 128'({13'd2, 13'd1}));
      end
      step();
    end
    step();
    chk("h_wr_c10_z", 128'(wr_en_o), 128'(1));
    chk("h_zero_write", 128'(wr_literals_o), 128'(0));
    repeat (4) step(); chk("h_done_r2", 128'(done_o), 128'(1));
    repeat (2) step(); chk("h_err_sticky", 128'(err_o), 128'(1));

    // Run 3: abort by reset at cycle 7
    cand_lits_i = mk(5, 'h1007, 9); start_i = 1; cyc = 0;
    step(); start_i = 0; chk("h_err_clear", 128'(err_o), 128'(0));
    repeat (4) step(); chk("h_err_r3", 128'(err_o), 128'(1));
    repeat (2) step(); rst_i = 0;
    step(); rst_i = 1;
    chk("h_abort_busy", 128'(busy_o), 128'(0));
    while (cyc <= 16) begin
      chk("h_abort_wr", 128'(wr_en_o), 128'(0));
      chk("h_abort_done", 128'(done_o), 128'(0));
      step();
    end

    // Run 4: start held during busy, then a clean restart after done
    ovr.delete();
    cand_lits_i = mk('h100B, 12, 'h100D); start_i = 1; cyc = 0;
    repeat (5) step();
    start_i = 0;
    step();
    wl = wr_literals_o;
    chk("h_r4_slot0", 128'(wl[0 +: REM_W]), 128'({13'd102, 13'd101}));
    repeat (8) step(); chk("h_done_r4", 128'(done_o), 128'(1));
    step();
    cand_lits_i = mk(0, 0, 6); start_i = 1; cyc = 0;
    step(); start_i = 0; chk("h_r5_rd", 128'(mem_rd_en_o), 128'(0));
    chk("h_r5_busy", 128'(busy_o), 128'(1));
    repeat (16) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
